// File: rtl/stdout_uart_tx_pkg.sv
// Shared definitions for the stdout UART transmitter: FSM encoding, line levels
// and default sizing.
package stdout_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  localparam int DEFAULT_CLKS_PER_BIT    = 104;
  localparam int DEFAULT_FIFO_DEPTH      = 16;
  localparam int DEFAULT_FIFO_ADDR_WIDTH = 4;

  // Width of a counter that must hold 0..clks-1; never narrower than one bit.
  function automatic int baud_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/stdout_uart_tx_byte_fifo.sv
// First-word-fall-through byte FIFO with occupancy count; dout is the head
// entry whenever empty is low.
module byte_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // push is ignored while full and pop while empty, judged on the count
  // before the edge, so a push on a full FIFO is dropped even if a pop
  // happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/stdout_uart_tx.sv
// Buffers bytes strobed out of the processor's stdout port and sends them as
// 8N1 UART, LSB first, throttling the processor through cpu_en.
module stdout_uart_tx
  import stdout_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
  parameter int FIFO_ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] stdout,
  input  logic       stdout_en,
  output logic       cpu_en,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BAUD_W = baud_width(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] CPU_EN_MAX = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH - 2);

  uart_state_t              state;
  uart_state_t              state_next;
  logic [BAUD_W-1:0]        baud_cnt;
  logic [BAUD_W-1:0]        baud_cnt_next;
  logic [2:0]               bit_cnt;
  logic [2:0]               bit_cnt_next;
  logic [7:0]               shift;
  logic [7:0]               shift_next;
  logic                     tx_next;
  logic                     bit_done;

  logic                     stdout_en_d;
  logic                     push;
  logic                     pop;
  logic [7:0]               fifo_dout;
  logic [FIFO_ADDR_WIDTH:0] fifo_count;
  logic                     fifo_empty;

  // A strobe held high while the processor is frozen must push only once.
  assign push = stdout_en && !stdout_en_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stdout_en_d <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      stdout_en_d <= stdout_en;
      if (push && fifo_full) overflow <= 1'b1;
    end
  end

  byte_fifo #(
    .WIDTH      (8),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (stdout),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift;
    tx_next       = tx;
    pop           = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_next = UART_STOP_BIT;
        if (!fifo_empty) begin
          pop           = 1'b1;
          shift_next    = fifo_dout;
          tx_next       = UART_START_BIT;
          baud_cnt_next = '0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
          tx_next       = shift[0];
          state_next    = ST_DATA;
        end else begin
          baud_cnt_next = baud_cnt + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          if (bit_cnt == 3'd7) begin
            tx_next    = UART_STOP_BIT;
            state_next = ST_STOP;
          end else begin
            shift_next   = {1'b0, shift[7:1]};
            tx_next      = shift[1];
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          // Chain straight into the next start bit so queued bytes go out
          // without an idle gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_dout;
            tx_next    = UART_START_BIT;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        tx_next    = UART_STOP_BIT;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx       <= UART_STOP_BIT;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      tx       <= tx_next;
      baud_cnt <= baud_cnt_next;
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
    end
  end

  // One free slot remains when cpu_en drops, enough for a push already in flight.
  always_comb begin
    cpu_en = (fifo_count <= CPU_EN_MAX);
    busy   = (state != ST_IDLE) || !fifo_empty;
  end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Directed bench for stdout_uart_tx (4 clocks per bit, 4-entry FIFO); a UART
// receiver process checks decoded bytes against the expected queue.
module tb_stdout_uart_tx;

  logic       clk;
  logic       reset;
  logic [7:0] stdout;
  logic       stdout_en;
  logic       cpu_en;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int start_cycles[$];

  stdout_uart_tx #(
    .CLKS_PER_BIT    (4),
    .FIFO_DEPTH      (4),
    .FIFO_ADDR_WIDTH (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stdout    (stdout),
    .stdout_en (stdout_en),
    .cpu_en    (cpu_en),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver: strobe one byte for one cycle, then idle gap cycles; returns at
  // the falling edge right after the capture edge.
  task automatic send(input logic [7:0] b, input int gap);
    stdout    = b;
    stdout_en = 1'b1;
    @(negedge clk);
    stdout_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  // monitor: UART receiver sampling mid-bit, aborts on reset
  initial begin : monitor
    logic [7:0] rx_byte;
    logic [7:0] exp_b;
    bit aborted;
    forever begin
      @(negedge clk);
      if (!reset && tx == 1'b0) begin
        start_cycles.push_back(cyc);
        aborted = 1'b0;
        rx_byte = 8'h00;
        for (int c = 1; c <= 38; c++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (c == 2) check("start_bit", tx, 1'b0);
          if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) rx_byte[(c - 6) / 4] = tx;
          if (c == 38) check("stop_bit", tx, 1'b1);
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte %02h, expected no frame", rx_byte);
          end else begin
            exp_b = exp_q.pop_front();
            check("rx_byte", rx_byte, exp_b);
          end
        end
      end
    end
  end

  // stimulus
  initial begin : stimulus
    logic [9:0] frame;
    logic [7:0] bp_bytes [5];
    int n;

    reset     = 1'b1;
    stdout    = 8'h00;
    stdout_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_fifo_full", fifo_full, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_cpu_en", cpu_en, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single byte 8'h41, exact waveform: start, 1,0,0,0,0,0,1,0, stop
    frame = 10'b1_0100_0001_0;
    exp_q.push_back(8'h41);
    send(8'h41, 0);
    check("single_pre_tx", tx, 1'b1);
    check("single_pre_busy", busy, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx !== frame[k / 4]) begin
        checks++;
        errors++;
        $display("FAIL single_wave: cycle %0d got tx=%b, expected %b", k, tx, frame[k / 4]);
      end else begin
        checks++;
      end
      if (k == 0 || k == 39) check("single_busy", busy, 1'b1);
    end
    @(negedge clk);
    check("single_post_busy", busy, 1'b0);
    check("single_post_tx", tx, 1'b1);
    wait_idle("single", 100);

    // held strobe: one push only
    exp_q.push_back(8'h55);
    stdout    = 8'h55;
    stdout_en = 1'b1;
    repeat (10) @(negedge clk);
    check("held_cpu_en", cpu_en, 1'b1);
    check("held_fifo_full", fifo_full, 1'b0);
    stdout_en = 1'b0;
    wait_idle("held", 200);

    // back-to-back frames, no gap between stop and next start
    start_cycles.delete();
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    send(8'h48, 3);
    send(8'h69, 3);
    wait_idle("b2b", 200);
    check("b2b_frames", start_cycles.size(), 2);
    if (start_cycles.size() == 2)
      check("b2b_gap", start_cycles[1] - start_cycles[0], 40);

    // backpressure: pulse generator gated by cpu_en
    bp_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!cpu_en && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("bp_wait_cpu_en", cpu_en, 1'b1);
      exp_q.push_back(bp_bytes[i]);
      send(bp_bytes[i], 0);
      if (i == 2) check("bp_cpu_en_cnt2", cpu_en, 1'b1);
      if (i == 3) check("bp_cpu_en_cnt3", cpu_en, 1'b0);
      repeat (3) @(negedge clk);
    end
    check("bp_overflow", overflow, 1'b0);
    wait_idle("bp", 400);
    check("bp_overflow_end", overflow, 1'b0);

    // overflow: six rapid pushes, first is popped at once, sixth is dropped
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(8'(i));
      send(8'(i), 1);
      if (i == 5) begin
        check("ovf_full_5", fifo_full, 1'b1);
        check("ovf_flag_5", overflow, 1'b0);
        check("ovf_cpu_en_5", cpu_en, 1'b0);
      end
      if (i == 6) begin
        check("ovf_full_6", fifo_full, 1'b1);
        check("ovf_flag_6", overflow, 1'b1);
      end
    end
    wait_idle("ovf", 400);
    check("ovf_sticky", overflow, 1'b1);

    // reset during data bit 3 of 8'h00
    send(8'h00, 0);
    repeat (18) @(negedge clk);
    check("mid_pre_tx", tx, 1'b0);
    check("mid_pre_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cpu_en", cpu_en, 1'b1);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_fifo_full", fifo_full, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h3C);
    send(8'h3C, 0);
    wait_idle("post_rst", 100);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
